// File: rtl/i2s_transceiver_if.sv
// I2S transceiver bus: codec pins plus the sample-side rx strobe and tx handshake.
// The master modport is the transceiver's view; slave is the user/codec side.
interface i2s_transceiver_if #(
  parameter int DataWidth = 24
);
  logic                 enable;
  logic                 mclk;
  logic                 sclk;
  logic                 lrck;
  logic                 adc;
  logic                 dac;
  logic [DataWidth-1:0] rxData;
  logic                 rxChannel;
  logic                 rxValid;
  logic [DataWidth-1:0] txLeft;
  logic [DataWidth-1:0] txRight;
  logic                 txValid;
  logic                 txReady;
  logic                 underrun;
  logic                 clearUnderrun;

  modport master (
    input  enable, adc, txLeft, txRight, txValid, clearUnderrun,
    output mclk, sclk, lrck, dac, rxData, rxChannel, rxValid, txReady, underrun
  );

  modport slave (
    output enable, adc, txLeft, txRight, txValid, clearUnderrun,
    input  mclk, sclk, lrck, dac, rxData, rxChannel, rxValid, txReady, underrun
  );
endinterface

// File: rtl/i2s_transceiver.sv
// I2S master transceiver: generates mclk/sclk/lrck from clk, serialises a buffered
// stereo pair with the standard one-bit delay and deserialises the ADC stream.
module i2s_transceiver #(
  parameter int DataWidth = 24,
  parameter int SlotBits  = 32,
  parameter int MclkDiv   = 2,
  parameter int SclkDiv   = 8
) (
  input  logic                clk,
  input  logic                resetN,
  i2s_transceiver_if.master   bus
);
  localparam int MW = (MclkDiv > 1) ? $clog2(MclkDiv) : 1;
  localparam int SW = $clog2(SclkDiv);
  localparam int BW = $clog2(SlotBits);
  localparam logic [MW-1:0] MclkLast = MW'(MclkDiv - 1);
  localparam logic [MW-1:0] MclkOne  = MW'(1);
  localparam logic [SW-1:0] SclkLast = SW'(SclkDiv - 1);
  localparam logic [SW-1:0] SclkOne  = SW'(1);
  localparam logic [BW-1:0] BitLast  = BW'(SlotBits - 1);
  localparam logic [BW-1:0] BitOne   = BW'(1);
  localparam logic [BW-1:0] BitData  = BW'(DataWidth);
  localparam logic [DataWidth-1:0] Zero = {DataWidth{1'b0}};

  logic                 running_r;
  logic [MW-1:0]        mdiv_r;
  logic [SW-1:0]        sdiv_r;
  logic [BW-1:0]        bit_r;
  logic                 mclk_r, sclk_r, lrck_r, dac_r;
  logic [DataWidth-1:0] tx_left_sr_r, tx_right_sr_r, rx_sr_r;
  logic [DataWidth-1:0] rx_data_r;
  logic                 rx_channel_r, rx_valid_r;
  logic [DataWidth-1:0] hold_left_r, hold_right_r;
  logic                 tx_ready_r, underrun_r;

  logic                 sclk_rise_s, sclk_fall_s, bit_wrap_s, frame_start_s;
  logic                 tx_bit_s, rx_bit_s, accept_s;
  logic [BW-1:0]        bit_next_s;

  assign sclk_rise_s   = (sdiv_r == SclkLast) && !sclk_r;
  assign sclk_fall_s   = (sdiv_r == SclkLast) && sclk_r;
  assign bit_wrap_s    = (bit_r == BitLast);
  assign bit_next_s    = bit_wrap_s ? {BW{1'b0}} : bit_r + BitOne;
  // A frame starts on the right->left wrap, or on the first cycle after enable rises.
  assign frame_start_s = bus.enable && (!running_r || (sclk_fall_s && bit_wrap_s && lrck_r));
  assign tx_bit_s      = (bit_next_s >= BitOne) && (bit_next_s <= BitData);
  assign rx_bit_s      = (bit_r >= BitOne) && (bit_r <= BitData);
  assign accept_s      = bus.txValid && tx_ready_r;

  // Clock generation, bit/slot counting, serialiser and deserialiser.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      running_r     <= 1'b0;
      mdiv_r        <= {MW{1'b0}};
      sdiv_r        <= {SW{1'b0}};
      bit_r         <= {BW{1'b0}};
      mclk_r        <= 1'b0;
      sclk_r        <= 1'b0;
      lrck_r        <= 1'b0;
      dac_r         <= 1'b0;
      tx_left_sr_r  <= Zero;
      tx_right_sr_r <= Zero;
      rx_sr_r       <= Zero;
      rx_data_r     <= Zero;
      rx_channel_r  <= 1'b0;
      rx_valid_r    <= 1'b0;
    end else if (!bus.enable) begin
      running_r     <= 1'b0;
      mdiv_r        <= {MW{1'b0}};
      sdiv_r        <= {SW{1'b0}};
      bit_r         <= {BW{1'b0}};
      mclk_r        <= 1'b0;
      sclk_r        <= 1'b0;
      lrck_r        <= 1'b0;
      dac_r         <= 1'b0;
      tx_left_sr_r  <= Zero;
      tx_right_sr_r <= Zero;
      rx_sr_r       <= Zero;
      rx_valid_r    <= 1'b0;
    end else begin
      running_r  <= 1'b1;
      rx_valid_r <= 1'b0;
      if (mdiv_r == MclkLast) begin
        mdiv_r <= {MW{1'b0}};
        mclk_r <= ~mclk_r;
      end else begin
        mdiv_r <= mdiv_r + MclkOne;
      end
      if (sdiv_r == SclkLast) begin
        sdiv_r <= {SW{1'b0}};
        sclk_r <= ~sclk_r;
      end else begin
        sdiv_r <= sdiv_r + SclkOne;
      end
      if (sclk_fall_s) begin
        bit_r <= bit_next_s;
        if (bit_wrap_s) begin
          lrck_r <= ~lrck_r;
        end
        // Slot bits 1..DataWidth carry the sample MSB first; everything else idles low.
        if (tx_bit_s) begin
          if (lrck_r) begin
            dac_r         <= tx_right_sr_r[DataWidth-1];
            tx_right_sr_r <= {tx_right_sr_r[DataWidth-2:0], 1'b0};
          end else begin
            dac_r         <= tx_left_sr_r[DataWidth-1];
            tx_left_sr_r  <= {tx_left_sr_r[DataWidth-2:0], 1'b0};
          end
        end else begin
          dac_r <= 1'b0;
        end
      end
      if (frame_start_s) begin
        tx_left_sr_r  <= tx_ready_r ? Zero : hold_left_r;
        tx_right_sr_r <= tx_ready_r ? Zero : hold_right_r;
      end
      if (sclk_rise_s && rx_bit_s) begin
        rx_sr_r <= {rx_sr_r[DataWidth-2:0], bus.adc};
        if (bit_r == BitData) begin
          rx_data_r    <= {rx_sr_r[DataWidth-2:0], bus.adc};
          rx_channel_r <= lrck_r;
          rx_valid_r   <= 1'b1;
        end
      end
    end
  end

  // Holding buffer, tx handshake and sticky underrun; unaffected by enable.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hold_left_r  <= Zero;
      hold_right_r <= Zero;
      tx_ready_r   <= 1'b1;
      underrun_r   <= 1'b0;
    end else begin
      if (frame_start_s && tx_ready_r) begin
        underrun_r <= 1'b1;
      end else if (bus.clearUnderrun) begin
        underrun_r <= 1'b0;
      end
      // A pair accepted on an empty-buffer frame start waits for the next frame.
      if (accept_s) begin
        hold_left_r  <= bus.txLeft;
        hold_right_r <= bus.txRight;
        tx_ready_r   <= 1'b0;
      end else if (frame_start_s && !tx_ready_r) begin
        tx_ready_r   <= 1'b1;
      end
    end
  end

  assign bus.mclk      = mclk_r;
  assign bus.sclk      = sclk_r;
  assign bus.lrck      = lrck_r;
  assign bus.dac       = dac_r;
  assign bus.rxData    = rx_data_r;
  assign bus.rxChannel = rx_channel_r;
  assign bus.rxValid   = rx_valid_r;
  assign bus.txReady   = tx_ready_r;
  assign bus.underrun  = underrun_r;
endmodule
